// File: rtl/cpu_bus_tracer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_bus_tracer_pkg : trace entry layout, capture modes, qualifier     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cpu_bus_tracer_pkg;

  localparam int ENTRY_W      = 26;
  localparam int ENT_D_LSB    = 0;
  localparam int ENT_A_LSB    = 8;
  localparam int ENT_RW_BIT   = 24;
  localparam int ENT_SYNC_BIT = 25;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_SYNC  = 2'd2,
    MODE_WRITE = 2'd3
  } trace_mode_e;

  // Field order matches the packed trace entry {sync,rw,A,D}.
  typedef struct packed {
    logic        sync;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_entry_t;

  function automatic logic qualifies(input logic [1:0] mode, input bus_entry_t e);
    case (trace_mode_e'(mode))
      MODE_ALL:   return 1'b1;
      MODE_SYNC:  return e.sync;
      MODE_WRITE: return !e.rw;
      default:    return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_tracer_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_bus_tracer_ram : simple dual-port trace store, registered read    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cpu_bus_tracer_ram #(
  parameter int AW = 8,
  parameter int DW = 26
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_tracer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_bus_tracer : 6502 bus sync, N-window decode, triggered trace      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cpu_bus_tracer
  import cpu_bus_tracer_pkg::*;
#(
  parameter int                      N_REGIONS   = 4,
  parameter logic [N_REGIONS*16-1:0] MASKS       = {16'h8000, 16'hC000, 16'hF000, 16'hFF00},
  parameter logic [N_REGIONS*16-1:0] PATTERNS    = {16'h0000, 16'h4000, 16'hE000, 16'hFF00},
  parameter int                      DEPTH_LOG2  = 8,
  parameter int                      SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PHI2,
  input  logic                  RW,
  input  logic                  SYNC,
  input  logic [15:0]           A,
  input  logic [7:0]            D,
  output logic [N_REGIONS-1:0]  cs_n,
  output logic [N_REGIONS-1:0]  wr_strobe,
  output logic [N_REGIONS-1:0]  rd_strobe,
  output logic [15:0]           cyc_addr,
  output logic [7:0]            cyc_data,
  input  logic [1:0]            mode,
  input  logic                  arm,
  input  logic                  trig_en,
  input  logic [15:0]           trig_addr,
  input  logic [DEPTH_LOG2-1:0] post_count,
  output logic                  armed,
  output logic                  triggered,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   count,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [ENTRY_W-1:0]    rd_data
);

  localparam int                SYNC_W     = ENTRY_W + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  function automatic logic [N_REGIONS-1:0] prio_hit(input logic [15:0] a);
    logic [N_REGIONS-1:0] r;
    logic                 found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (!found && ((a & MASKS[16*i +: 16]) == PATTERNS[16*i +: 16])) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Chip selects follow the raw bus so external devices see no sync delay.
  assign cs_n = ~(prio_hit(A) & {N_REGIONS{PHI2 & rst_n}});

  logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q;
  logic [SYNC_W-1:0]                  sync_s;
  bus_entry_t                         bus_s;
  logic                               phi2_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], {PHI2, SYNC, RW, A, D}};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign phi2_s = sync_s[SYNC_W-1];
  assign bus_s  = bus_entry_t'(sync_s[ENTRY_W-1:0]);

  bus_entry_t           lat_q;
  logic                 phi2_prev_q;
  logic                 fall;
  logic [N_REGIONS-1:0] hit_lat;
  logic [N_REGIONS-1:0] wr_strobe_q, rd_strobe_q;
  logic [15:0]          cyc_addr_q;
  logic [7:0]           cyc_data_q;

  assign fall    = phi2_prev_q & ~phi2_s;
  assign hit_lat = prio_hit(lat_q.addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q       <= '0;
      phi2_prev_q <= 1'b0;
      wr_strobe_q <= '0;
      rd_strobe_q <= '0;
      cyc_addr_q  <= '0;
      cyc_data_q  <= '0;
    end else begin
      phi2_prev_q <= phi2_s;
      if (phi2_s) lat_q <= bus_s;
      wr_strobe_q <= (fall && !lat_q.rw) ? hit_lat : '0;
      rd_strobe_q <= (fall &&  lat_q.rw) ? hit_lat : '0;
      if (fall) begin
        cyc_addr_q <= lat_q.addr;
        cyc_data_q <= lat_q.data;
      end
    end
  end

  logic                  armed_q, armed_d;
  logic                  triggered_q, triggered_d;
  logic                  done_q, done_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] post_q, post_d;
  logic                  cap;
  logic                  ram_we;

  assign cap = armed_q && fall && qualifies(mode, lat_q);

  always_comb begin
    armed_d     = armed_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    post_d      = post_q;
    ram_we      = 1'b0;
    if (arm) begin
      armed_d     = 1'b1;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      count_d     = '0;
      wr_ptr_d    = '0;
    end else if (cap) begin
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != DEPTH_FULL) count_d = count_q + 1'b1;
      if (trig_en && (lat_q.addr == trig_addr) && !triggered_q) begin
        triggered_d = 1'b1;
        post_d      = post_count;
        if (post_count == '0) begin
          armed_d = 1'b0;
          done_d  = 1'b1;
        end
      end else if (triggered_q) begin
        post_d = post_q - 1'b1;
        if (post_q == {{(DEPTH_LOG2-1){1'b0}}, 1'b1}) begin
          armed_d = 1'b0;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      post_q      <= '0;
    end else begin
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      post_q      <= post_d;
    end
  end

  // Index 0 is the oldest entry; truncating count is the mod-depth wrap.
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [ENTRY_W-1:0]    ram_rdata;
  logic                  rd_valid_q;

  assign rd_addr = wr_ptr_q - count_q[DEPTH_LOG2-1:0] + rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= ({1'b0, rd_idx} < count_q);
  end

  cpu_bus_tracer_ram #(
    .AW (DEPTH_LOG2),
    .DW (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (lat_q),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign rd_data   = rd_valid_q ? ram_rdata : '0;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign cyc_addr  = cyc_addr_q;
  assign cyc_data  = cyc_data_q;
  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_tracer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_bus_tracer : directed self-checking bench for cpu_bus_tracer   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cpu_bus_tracer;

  localparam int          NR = 4;
  localparam int          DL = 3;
  localparam logic [63:0] TB_MASKS = {16'h8000, 16'hC000, 16'hF000, 16'hFF00};
  localparam logic [63:0] TB_PATS  = {16'h0000, 16'h4000, 16'hF000, 16'hFF00};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          PHI2, RW, SYNC;
  logic [15:0]   A;
  logic [7:0]    D;
  logic [NR-1:0] cs_n, wr_strobe, rd_strobe;
  logic [15:0]   cyc_addr;
  logic [7:0]    cyc_data;
  logic [1:0]    mode;
  logic          arm, trig_en;
  logic [15:0]   trig_addr;
  logic [DL-1:0] post_count, rd_idx;
  logic          armed, triggered, done;
  logic [DL:0]   count;
  logic [25:0]   rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses [NR];
  int rd_pulses [NR];
  logic [25:0] got;

  always #20 clk = ~clk;

  cpu_bus_tracer #(
    .N_REGIONS   (NR),
    .MASKS       (TB_MASKS),
    .PATTERNS    (TB_PATS),
    .DEPTH_LOG2  (DL),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PHI2       (PHI2),
    .RW         (RW),
    .SYNC       (SYNC),
    .A          (A),
    .D          (D),
    .cs_n       (cs_n),
    .wr_strobe  (wr_strobe),
    .rd_strobe  (rd_strobe),
    .cyc_addr   (cyc_addr),
    .cyc_data   (cyc_data),
    .mode       (mode),
    .arm        (arm),
    .trig_en    (trig_en),
    .trig_addr  (trig_addr),
    .post_count (post_count),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done),
    .count      (count),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] ent(input logic [15:0] a, input logic [7:0] d,
                                      input logic rw, input logic sy);
    return {sy, rw, a, d};
  endfunction

  function automatic logic [7:0] dpat(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // One full bus cycle starting at a negedge; counts strobe pulses seen in the low phase.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic sy);
    for (int i = 0; i < NR; i++) begin
      wr_pulses[i] = 0;
      rd_pulses[i] = 0;
    end
    A = a; D = d; RW = rw; SYNC = sy; PHI2 = 1'b1;
    repeat (4) @(negedge clk);
    PHI2 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        wr_pulses[i] += int'(wr_strobe[i]);
        rd_pulses[i] += int'(rd_strobe[i]);
      end
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic read_entry(input logic [DL-1:0] idx, output logic [25:0] val);
    rd_idx = idx;
    @(negedge clk);
    val = rd_data;
  endtask

  initial begin
    rst_n = 1'b0; PHI2 = 1'b0; RW = 1'b1; SYNC = 1'b0; A = 16'h0000; D = 8'h00;
    mode = 2'd0; arm = 1'b0; trig_en = 1'b0; trig_addr = 16'h0000; post_count = '0; rd_idx = '0;
    repeat (3) @(negedge clk);
    check_eq("reset cs_n", 32'(cs_n), 32'hF);
    check_eq("reset strobes", 32'({wr_strobe, rd_strobe}), 32'h0);
    check_eq("reset flags", 32'({armed, triggered, done}), 32'h0);
    check_eq("reset count", 32'(count), 32'h0);
    check_eq("reset rd_data", 32'(rd_data), 32'h0);
    check_eq("reset cyc", 32'({cyc_addr, cyc_data}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Priority decode: FF10 hits regions 0 and 1, region 0 wins.
    A = 16'hFF10; PHI2 = 1'b1;
    #1 check_eq("cs_n FF10", 32'(cs_n), 32'hE);
    @(negedge clk);
    bus_cycle(16'hFF10, 8'hA5, 1'b0, 1'b0);
    check_eq("wr_strobe[0] pulses", wr_pulses[0], 1);
    check_eq("wr_strobe others", wr_pulses[1] + wr_pulses[2] + wr_pulses[3], 0);
    check_eq("rd_strobe on write", rd_pulses[0] + rd_pulses[1] + rd_pulses[2] + rd_pulses[3], 0);
    check_eq("cyc_addr write", 32'(cyc_addr), 32'hFF10);
    check_eq("cyc_data write", 32'(cyc_data), 32'hA5);
    #1 check_eq("cs_n PHI2 low", 32'(cs_n), 32'hF);
    @(negedge clk);
    A = 16'hF123; PHI2 = 1'b1;
    #1 check_eq("cs_n F123", 32'(cs_n), 32'hD);
    @(negedge clk);
    bus_cycle(16'hF123, 8'h3C, 1'b1, 1'b0);
    check_eq("rd_strobe[1] pulses", rd_pulses[1], 1);
    check_eq("rd_strobe others", rd_pulses[0] + rd_pulses[2] + rd_pulses[3], 0);
    check_eq("cyc_data read", 32'(cyc_data), 32'h3C);
    check_eq("mode 0 no capture", 32'(count), 32'h0);

    // Wrap: 10 cycles into an 8-deep buffer.
    mode = 2'd1;
    pulse_arm();
    check_eq("armed after arm", 32'(armed), 32'h1);
    for (int i = 0; i < 10; i++) bus_cycle(16'(i), dpat(16'(i)), 1'b1, 1'b0);
    check_eq("wrap count", 32'(count), 32'h8);
    read_entry(3'd0, got);
    check_eq("wrap idx0", 32'(got), 32'(ent(16'h0002, dpat(16'h0002), 1'b1, 1'b0)));
    read_entry(3'd7, got);
    check_eq("wrap idx7", 32'(got), 32'(ent(16'h0009, dpat(16'h0009), 1'b1, 1'b0)));

    // Trigger at 0005 with two post-trigger entries.
    trig_en = 1'b1; trig_addr = 16'h0005; post_count = 3'd2;
    pulse_arm();
    for (int i = 0; i < 10; i++) bus_cycle(16'(i), dpat(16'(i)), 1'b1, 1'b0);
    check_eq("trig flags", 32'({armed, triggered, done}), 32'h3);
    check_eq("trig count", 32'(count), 32'h8);
    read_entry(3'd7, got);
    check_eq("trig idx7", 32'(got), 32'(ent(16'h0007, dpat(16'h0007), 1'b1, 1'b0)));
    read_entry(3'd0, got);
    check_eq("trig idx0", 32'(got), 32'(ent(16'h0000, dpat(16'h0000), 1'b1, 1'b0)));
    trig_en = 1'b0;

    // Mode filtering over a fixed mix of cycles.
    for (int m = 2; m >= 0; m--) begin
      mode = (m == 2) ? 2'd2 : (m == 1) ? 2'd3 : 2'd0;
      pulse_arm();
      bus_cycle(16'h0010, 8'h10, 1'b1, 1'b1);
      bus_cycle(16'h0011, 8'h11, 1'b1, 1'b0);
      bus_cycle(16'h0012, 8'h12, 1'b0, 1'b0);
      bus_cycle(16'h0013, 8'h13, 1'b1, 1'b1);
      if (m == 2) begin
        check_eq("mode2 count", 32'(count), 32'h2);
        read_entry(3'd0, got);
        check_eq("mode2 idx0", 32'(got), 32'(ent(16'h0010, 8'h10, 1'b1, 1'b1)));
        read_entry(3'd1, got);
        check_eq("mode2 idx1", 32'(got), 32'(ent(16'h0013, 8'h13, 1'b1, 1'b1)));
      end else if (m == 1) begin
        check_eq("mode3 count", 32'(count), 32'h1);
        read_entry(3'd0, got);
        check_eq("mode3 idx0", 32'(got), 32'(ent(16'h0012, 8'h12, 1'b0, 1'b0)));
        read_entry(3'd1, got);
        check_eq("mode3 idx beyond count", 32'(got), 32'h0);
      end else begin
        check_eq("mode0 count", 32'(count), 32'h0);
      end
    end

    // Arm coincident with the clk in which the falling edge is detected.
    mode = 2'd1;
    pulse_arm();
    bus_cycle(16'h0020, 8'h20, 1'b1, 1'b0);
    check_eq("pre-collision count", 32'(count), 32'h1);
    A = 16'h0021; D = 8'h21; RW = 1'b1; SYNC = 1'b0; PHI2 = 1'b1;
    repeat (4) @(negedge clk);
    PHI2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("collision count", 32'(count), 32'h0);
    check_eq("collision armed", 32'(armed), 32'h1);
    bus_cycle(16'h0022, 8'h22, 1'b1, 1'b0);
    check_eq("post-collision count", 32'(count), 32'h1);
    read_entry(3'd0, got);
    check_eq("post-collision idx0", 32'(got), 32'(ent(16'h0022, 8'h22, 1'b1, 1'b0)));

    // Asynchronous reset in the middle of an active bus cycle.
    A = 16'hFF10; D = 8'h77; RW = 1'b0; PHI2 = 1'b1;
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    check_eq("midreset cs_n", 32'(cs_n), 32'hF);
    check_eq("midreset strobes", 32'({wr_strobe, rd_strobe}), 32'h0);
    check_eq("midreset count", 32'(count), 32'h0);
    check_eq("midreset flags", 32'({armed, triggered, done}), 32'h0);
    check_eq("midreset rd_data", 32'(rd_data), 32'h0);
    @(negedge clk);
    PHI2 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
